// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the EX-stage multiply/divide unit.
//   - MDU op code localparams (4-bit, carried in the ID/EX register)
//   - default busy-cycle counts for multiply and divide
//   - is_multi_cycle(): true for ops that occupy the unit for several cycles
// Build option: MDU_MADD_EN enables the MADD/MADDU/MSUB/MSUBU accumulate ops;
// without it those codes are treated like NONE.
package mdu_pkg;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  function automatic logic is_multi_cycle(input logic [3:0] op);
    logic res;
    res = 1'b0;
    case (op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: res = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: res = 1'b1;
`endif
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/ex_mdu.sv
// ex_mdu: multi-cycle multiply/divide unit of the EX stage; owns HI/LO.
// The full result is computed combinationally at accept and parked in a
// 64-bit pending register; a 4-bit down-counter models the busy latency and
// HI/LO are committed on the edge where the counter steps from 1 to 0.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   start, op, a, b   MDU op presented by EX (op codes from mdu_pkg)
//   d_md              D-stage instruction touches the MDU
//   busy              operation in flight
//   stall_req         freeze PC/IF-ID/ID-EX while an MDU op is pending
//   hi, lo            architectural HI/LO registers
// Build option: MDU_MADD_EN adds MADD/MADDU/MSUB/MSUBU (latency MULT_CYCLES).
module ex_mdu
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        d_md,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  logic [3:0]  count_q;
  logic [63:0] pend_q;
  logic [31:0] hi_q, lo_q;

  logic        accept;
  logic [63:0] prod_s, prod_u;
  logic        div_signed, a_neg, b_neg;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, quot, rem;
  logic [63:0] result;
  logic [3:0]  cycles;

  assign busy      = (count_q != 4'd0);
  assign accept    = start && !busy;
  assign stall_req = d_md && (busy || (start && is_multi_cycle(op)));
  assign hi        = hi_q;
  assign lo        = lo_q;

  always_comb begin
    prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    prod_u = {32'd0, a} * {32'd0, b};

    // Signed divide via magnitudes: quotient truncates toward zero and the
    // remainder follows the dividend. 0x80000000 / -1 falls out as
    // 0x80000000 rem 0 because the magnitude 2^31 is representable unsigned.
    div_signed = (op == OP_DIV);
    a_neg      = div_signed && a[31];
    b_neg      = div_signed && b[31];
    a_mag      = a_neg ? (32'd0 - a) : a;
    b_mag      = b_neg ? (32'd0 - b) : b;
    q_mag      = (b_mag != 32'd0) ? (a_mag / b_mag) : 32'd0;
    r_mag      = (b_mag != 32'd0) ? (a_mag % b_mag) : 32'd0;
    quot       = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    rem        = a_neg ? (32'd0 - r_mag) : r_mag;

    result = {hi_q, lo_q};
    cycles = 4'd0;
    case (op)
      OP_MULT: begin
        result = prod_s;
        cycles = 4'(MULT_CYCLES);
      end
      OP_MULTU: begin
        result = prod_u;
        cycles = 4'(MULT_CYCLES);
      end
      OP_DIV, OP_DIVU: begin
        // Divide by zero still burns the full latency but commits old HI/LO.
        result = (b == 32'd0) ? {hi_q, lo_q} : {rem, quot};
        cycles = 4'(DIV_CYCLES);
      end
`ifdef MDU_MADD_EN
      OP_MADD: begin
        result = {hi_q, lo_q} + prod_s;
        cycles = 4'(MULT_CYCLES);
      end
      OP_MADDU: begin
        result = {hi_q, lo_q} + prod_u;
        cycles = 4'(MULT_CYCLES);
      end
      OP_MSUB: begin
        result = {hi_q, lo_q} - prod_s;
        cycles = 4'(MULT_CYCLES);
      end
      OP_MSUBU: begin
        result = {hi_q, lo_q} - prod_u;
        cycles = 4'(MULT_CYCLES);
      end
`endif
      default: begin
        result = {hi_q, lo_q};
        cycles = 4'd0;
      end
    endcase
  end

  // Accept only happens with count_q == 0, so it never overlaps a commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= 4'd0;
      pend_q  <= 64'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else if (accept && (op == OP_MTHI)) begin
      hi_q <= a;
    end else if (accept && (op == OP_MTLO)) begin
      lo_q <= a;
    end else if (accept && is_multi_cycle(op)) begin
      count_q <= cycles;
      pend_q  <= result;
    end else if (count_q != 4'd0) begin
      count_q <= count_q - 4'd1;
      if (count_q == 4'd1) begin
        hi_q <= pend_q[63:32];
        lo_q <= pend_q[31:0];
      end
    end
  end

endmodule

// File: tb/tb_ex_mdu.sv
// tb_ex_mdu: randomized self-checking bench for ex_mdu. A behavioural model
// computes HI/LO from plain integer arithmetic and the latency from the op
// class; busy, stall_req and HI/LO are checked every cycle of each op.
// Honors MDU_MADD_EN the same way as the design.
module tb_ex_mdu;
  import mdu_pkg::*;

  localparam int unsigned MC = 5;
  localparam int unsigned DC = 10;

  logic        clk = 1'b0;
  logic        reset, start, d_md;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic        busy, stall_req;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] m_hl;

  ex_mdu #(
    .MULT_CYCLES(MC),
    .DIV_CYCLES (DC)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .d_md     (d_md),
    .busy     (busy),
    .stall_req(stall_req),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int unsigned latency(input logic [3:0] o);
    if (o >= 4'd1 && o <= 4'd2) return MC;
    if (o >= 4'd3 && o <= 4'd4) return DC;
`ifdef MDU_MADD_EN
    if (o >= 4'd7 && o <= 4'd10) return MC;
`endif
    return 0;
  endfunction

  function automatic logic [63:0] model_result(input logic [3:0] o, input logic [31:0] x,
                                               input logic [31:0] y, input logic [63:0] hl);
    longint            sp;
    longint unsigned   up;
    int                sx, sy, q, r;
    sp = longint'($signed(x)) * longint'($signed(y));
    up = longint'({32'd0, x}) * longint'({32'd0, y});
    sx = $signed(x);
    sy = $signed(y);
    case (o)
      4'd1: return 64'(sp);
      4'd2: return 64'(up);
      4'd3: begin
        if (y == 32'd0) return hl;
        if (x == 32'h8000_0000 && y == 32'hffff_ffff) return {32'd0, 32'h8000_0000};
        q = sx / sy;
        r = sx % sy;
        return {32'(r), 32'(q)};
      end
      4'd4: begin
        if (y == 32'd0) return hl;
        return {x % y, x / y};
      end
      4'd5: return {x, hl[31:0]};
      4'd6: return {hl[63:32], x};
`ifdef MDU_MADD_EN
      4'd7:  return hl + 64'(sp);
      4'd8:  return hl + 64'(up);
      4'd9:  return hl - 64'(sp);
      4'd10: return hl - 64'(up);
`endif
      default: return hl;
    endcase
  endfunction

  // Called at a negedge; returns at the negedge of the first idle cycle
  // after the op, so consecutive calls exercise back-to-back issue.
  task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic dm, input bit inject);
    int unsigned n;
    logic [63:0] exp_hl;
    n      = latency(o);
    exp_hl = model_result(o, x, y, m_hl);
    start = 1'b1; op = o; a = x; b = y; d_md = dm;
    #1;
    check("busy_at_issue", 64'(busy), 64'd0);
    check("stall_at_issue", 64'(stall_req), 64'(dm && (n != 0)));
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i <= int'(n); i++) begin
      if (inject && i == 2) begin
        start = 1'b1; op = OP_MTHI; a = 32'hdead_beef;
      end
      #1;
      check("busy_run", 64'(busy), 64'd1);
      check("stall_run", 64'(stall_req), 64'(dm));
      check("hilo_hold", {hi, lo}, m_hl);
      @(negedge clk);
      start = 1'b0;
    end
    #1;
    check("busy_done", 64'(busy), 64'd0);
    check("stall_done", 64'(stall_req), 64'd0);
    check("hilo_done", {hi, lo}, exp_hl);
    m_hl = exp_hl;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = OP_NONE; a = '0; b = '0; d_md = 1'b1;
    m_hl = 64'd0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_stall", 64'(stall_req), 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    reset = 1'b0; d_md = 1'b0;
    @(negedge clk);

    run_op(OP_MULT, 32'hffff_fffd, 32'd5, 1'b1, 1'b1);
    check("mult_neg3x5", {hi, lo}, 64'hffff_ffff_ffff_fff1);
    run_op(OP_DIVU, 32'd7, 32'd2, 1'b0, 1'b0);
    check("divu_7_2", {hi, lo}, {32'd1, 32'd3});
    run_op(OP_DIV, 32'hffff_fff9, 32'd2, 1'b0, 1'b0);
    check("div_neg7_2", {hi, lo}, {32'hffff_ffff, 32'hffff_fffd});
    run_op(OP_MTHI, 32'h11, 32'd0, 1'b1, 1'b0);
    run_op(OP_MTLO, 32'h22, 32'd0, 1'b0, 1'b0);
    run_op(OP_DIV, 32'd5, 32'd0, 1'b1, 1'b0);
    check("div_by_zero", {hi, lo}, {32'h11, 32'h22});
    run_op(OP_DIV, 32'h8000_0000, 32'hffff_ffff, 1'b0, 1'b0);
    check("div_overflow", {hi, lo}, {32'd0, 32'h8000_0000});

    // Reset in the third busy cycle of a DIVU aborts it.
    start = 1'b1; op = OP_DIVU; a = 32'd100; b = 32'd7; d_md = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_hilo", {hi, lo}, 64'd0);
    reset = 1'b0;
    m_hl = 64'd0;
    repeat (DC + 2) @(negedge clk);
    #1;
    check("abort_no_wb", {hi, lo}, 64'd0);
    check("abort_idle", 64'(busy), 64'd0);
    @(negedge clk);

    run_op(OP_MTHI, 32'd0, 32'd0, 1'b0, 1'b0);
    run_op(OP_MTLO, 32'd10, 32'd0, 1'b0, 1'b0);
    run_op(OP_MADD, 32'd3, 32'd4, 1'b1, 1'b0);
`ifdef MDU_MADD_EN
    check("madd_3x4", {hi, lo}, {32'd0, 32'd22});
`else
    check("madd_disabled", {hi, lo}, {32'd0, 32'd10});
`endif

    for (int k = 0; k < 60; k++) begin
      logic [3:0]  ro;
      logic [31:0] ra, rb;
      ro = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(0, 9)) - 32'd4;
      if ($urandom_range(0, 7) == 0) rb = 32'd0;
      run_op(ro, ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_mdu.md
# ex_mdu

Multi-cycle multiply/divide unit for the EX stage of the five-stage pipelined MIPS core. It consumes the operands and decoded MDU operation held in the ID/EX pipeline register and owns the architectural HI/LO registers. It drives the stall request that freezes the ID/EX register and the stages before it while a multiply or divide is in flight.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (and madd family); legal 1..15
- DIV_CYCLES, 10, busy cycles for div/divu; legal 1..15

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  EX instruction is a valid MDU op this cycle (already gated by flush)
- op  in  4  MDU operation code (mdu_pkg)
- a  in  32  rs value (forwarded)
- b  in  32  rt value (forwarded)
- d_md  in  1  instruction in D stage is an MDU op (incl. mfhi/mflo/mthi/mtlo)
- busy  out  1  operation in flight
- stall_req  out  1  freeze PC/IF-ID/ID-EX, bubble into EX
- hi  out  32  HI register
- lo  out  32  LO register

## Operation
- Op codes: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MADD=7, MADDU=8, MSUB=9, MSUBU=10. Other values behave as NONE.
- Accept condition: start && !busy. If busy, start is ignored, with no state change.
- MULT/MULTU: the 64-bit product (signed/unsigned) is captured at accept and the counter is loaded with MULT_CYCLES. HI/LO are written {hi,lo}=product when the counter reaches 0.
- DIV/DIVU: quotient goes to lo, remainder to hi. The signed form truncates toward zero and the remainder takes the sign of a. The counter is loaded with DIV_CYCLES.
- Divide by zero: the counter still runs DIV_CYCLES and HI/LO remain unchanged at completion.
- DIV of 0x80000000 by 0xFFFFFFFF yields lo=0x80000000, hi=0.
- MTHI/MTLO: hi<=a or lo<=a at the accepting edge. No busy cycles.
- mfhi/mflo: read hi/lo combinationally outside this block. No op code.
- stall_req = d_md && (busy || (start && op in {MULT..DIVU, MADD..MSUBU})).
- Result is held in internal 64-bit pending registers. The counter is 4 bits, with busy = (counter != 0).

## Timing
- Reset: hi=0, lo=0, counter=0, pending=0, busy=0, stall_req=0 (d_md irrelevant).
- Accept at edge ending cycle T.
  - busy is high in cycles T+1 .. T+N.
  - HI/LO are written at the edge ending cycle T+N.
  - New values are visible, with busy low, in cycle T+N+1.
- MTHI/MTLO accepted at T: new value visible at T+1.
- Back-to-back: an op presented in the cycle busy falls is accepted in that cycle.
- Reset during busy aborts the operation. The pending result is discarded, hi/lo=0, and busy=0 next cycle.
- The counter never wraps. Decrement happens only when nonzero.

## Configuration
- MDU_MADD_EN defined: MADD/MADDU/MSUB/MSUBU are implemented.
  - {hi,lo} is updated to {hi,lo} ± product, signed or unsigned.
  - The product and the HI/LO base are sampled at accept.
  - Latency is MULT_CYCLES.
- Not defined: codes 7..10 behave as NONE. They cause no stall, no busy, and no HI/LO change.

## Structure
- mdu_pkg holds:
  - the op code localparams;
  - the default MULT_CYCLES/DIV_CYCLES constants;
  - the helper predicate "op is multi-cycle".
- No sub-module. Single always block for counter/pending/HI/LO, plus combinational result and stall logic.

## Test plan
- Reset, then MULT a=0xFFFFFFFD (−3), b=5 → busy for 5 cycles; at completion hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- DIVU a=7, b=2 → busy for 10 cycles, lo=3, hi=1. DIV a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV b=0 with hi=0x11, lo=0x22 preset via MTHI/MTLO → busy for 10 cycles, hi=0x11, lo=0x22 unchanged.
- d_md=1 during MULT → stall_req high in accept cycle and all 5 busy cycles, low in the completion+1 cycle. A second start while busy is ignored.
- Reset asserted in 3rd busy cycle of DIVU → next cycle busy=0, hi=lo=0, no later writeback.
- With MDU_MADD_EN: hi=0, lo=10, MADD a=3, b=4 → lo=22, hi=0. Without the macro the same op leaves lo=10 and busy never rises.
